// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if -- signal bundle between the pipeline stages and the central
// pipeline controller.
//
// Signals:
//   stallreq_id/ex/mem : stall requests raised by ID, EX and MEM
//   id_load            : instruction currently in ID is a load
//   id_rf_waddr        : destination register of the instruction in ID
//   id_rs_raddr/rt     : source registers read by the instruction in ID
//   br_e               : taken branch resolved this cycle, ID is squashed
//   excp_i/excp_pc_i   : exception from MEM and its handler address
//   stall_o            : per-stage stall bus {WB,MEM,EX,ID,IF,PC}
//   flush_o/new_pc_o   : pipeline flush and redirect target
//   lu_stall_o         : current stall is a load-use stall
//   stall_cnt_o        : running count of load-use stall cycles
//
// Modports:
//   master : the pipeline side (drives requests, consumes control)
//   slave  : the controller side
interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        id_load;
  logic [4:0]  id_rf_waddr;
  logic [4:0]  id_rs_raddr;
  logic [4:0]  id_rt_raddr;
  logic        br_e;
  logic        excp_i;
  logic [31:0] excp_pc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        lu_stall_o;
  logic [31:0] stall_cnt_o;

  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem,
    output id_load, id_rf_waddr, id_rs_raddr, id_rt_raddr,
    output br_e, excp_i, excp_pc_i,
    input  stall_o, flush_o, new_pc_o, lu_stall_o, stall_cnt_o
  );

  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem,
    input  id_load, id_rf_waddr, id_rs_raddr, id_rt_raddr,
    input  br_e, excp_i, excp_pc_i,
    output stall_o, flush_o, new_pc_o, lu_stall_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- central pipeline controller for the five-stage in-order core.
//
// Merges stall requests from ID/EX/MEM, detects load-use hazards against the
// instruction in ID with a two-slot load scoreboard (loads in EX and MEM),
// sequences the two-cycle exception redirect (freeze, then flush + new PC),
// and counts load-use stall cycles.
//
// Ports:
//   clk : clock, all state on rising edge
//   rst : asynchronous active-high reset
//   bus : pipe_ctrl_if.slave bundle (requests in, stall/flush/redirect out)
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  logic [0:0]  state_q;
  logic [0:0]  state_d;

  logic        ex_v;
  logic [4:0]  ex_waddr;
  logic        mem_v;
  logic [4:0]  mem_waddr;

  logic [31:0] pc_q;
  logic [31:0] cnt_q;

  logic        ex_hit;
  logic        mem_hit;
  logic        lu;
  logic [5:0]  prio_stall;
  logic [5:0]  stall;
  logic        flush;
  logic        lu_stall;

  // Register 0 is never recorded in the scoreboard, so no $0 guard is needed
  // here. Loads that reached WB are covered by the regfile write bypass.
  assign ex_hit  = ex_v  & ((ex_waddr  == bus.id_rs_raddr) | (ex_waddr  == bus.id_rt_raddr));
  assign mem_hit = mem_v & ((mem_waddr == bus.id_rs_raddr) | (mem_waddr == bus.id_rt_raddr));
  assign lu      = ex_hit | mem_hit;

  // Deepest requesting stage wins: stalling a later stage implies stalling
  // everything in front of it.
  always_comb begin
    prio_stall = STALL_NONE;
    if (bus.stallreq_mem)
      prio_stall = STALL_MEM;
    else if (bus.stallreq_ex)
      prio_stall = STALL_EX;
    else if (bus.stallreq_id | lu)
      prio_stall = STALL_ID;
  end

  // An exception in IDLE freezes the whole pipe for one cycle; during FLUSH
  // nothing stalls and further requests/exceptions are dropped.
  always_comb begin
    stall   = prio_stall;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.excp_i) begin
          stall   = STALL_ALL;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        stall   = STALL_NONE;
        state_d = IDLE;
      end
      default: begin
        stall   = STALL_NONE;
        state_d = IDLE;
      end
    endcase
  end

  assign flush    = (state_q == FLUSH);
  assign lu_stall = lu & (stall == STALL_ID);

  // Exception sequencer and the handler address latched on entry to FLUSH.
  // The address is kept afterwards; consumers qualify it with flush_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && bus.excp_i)
        pc_q <= bus.excp_pc_i;
    end
  end

  // Load scoreboard. A slot holds while its stage is frozen and becomes a
  // bubble when the stage in front of it is frozen. A squashed or stalled
  // ID instruction enters EX as a bubble and must not be recorded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_v      <= 1'b0;
      ex_waddr  <= 5'd0;
      mem_v     <= 1'b0;
      mem_waddr <= 5'd0;
    end else if (flush) begin
      ex_v      <= 1'b0;
      ex_waddr  <= 5'd0;
      mem_v     <= 1'b0;
      mem_waddr <= 5'd0;
    end else begin
      if (!stall[3]) begin
        if (stall[2] | bus.br_e) begin
          ex_v     <= 1'b0;
          ex_waddr <= 5'd0;
        end else begin
          ex_v     <= bus.id_load & (bus.id_rf_waddr != 5'd0);
          ex_waddr <= bus.id_rf_waddr;
        end
      end
      if (!stall[4]) begin
        if (stall[3]) begin
          mem_v     <= 1'b0;
          mem_waddr <= 5'd0;
        end else begin
          mem_v     <= ex_v;
          mem_waddr <= ex_waddr;
        end
      end
    end
  end

  // Load-use stall cycle counter, free-running with natural wrap. A flush
  // does not clear it; only reset does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= 32'd0;
    else if (lu_stall)
      cnt_q <= cnt_q + 32'd1;
  end

  assign bus.stall_o     = stall;
  assign bus.flush_o     = flush;
  assign bus.new_pc_o    = pc_q;
  assign bus.lu_stall_o  = lu_stall;
  assign bus.stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- directed testbench for pipe_ctrl.
//
// Inputs are driven 1 time unit after each rising edge; outputs are checked
// on the following falling edge, except for the asynchronous reset case which
// is checked between edges.
module tb_pipe_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive every controller input for the coming cycle.
  task automatic applyStimulus(
    input logic        sid,
    input logic        sex,
    input logic        smem,
    input logic        ld,
    input logic [4:0]  wa,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic        br,
    input logic        exc,
    input logic [31:0] pc
  );
    bus.stallreq_id  = sid;
    bus.stallreq_ex  = sex;
    bus.stallreq_mem = smem;
    bus.id_load      = ld;
    bus.id_rf_waddr  = wa;
    bus.id_rs_raddr  = rs;
    bus.id_rt_raddr  = rt;
    bus.br_e         = br;
    bus.excp_i       = exc;
    bus.excp_pc_i    = pc;
  endtask

  // One comparison: observed against a hand-computed expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    applyStimulus(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 32'h0);

    // Reset state
    advance();
    settle();
    checkOutput("rst_stall", {26'd0, bus.stall_o}, 32'h00);
    checkOutput("rst_flush", {31'd0, bus.flush_o}, 32'h0);
    checkOutput("rst_new_pc", bus.new_pc_o, 32'h0);
    checkOutput("rst_cnt", bus.stall_cnt_o, 32'd0);
    checkOutput("rst_lu", {31'd0, bus.lu_stall_o}, 32'h0);
    advance();
    rst = 1'b0;
    $display("[TB] reset released");

    // Load-use: lw $8 then a reader of $8
    applyStimulus(0, 0, 0, 1, 5'd8, 5'd1, 5'd2, 0, 0, 32'h0);
    settle();
    checkOutput("lu_c0_stall", {26'd0, bus.stall_o}, 32'h00);
    advance();
    applyStimulus(0, 0, 0, 0, 5'd3, 5'd8, 5'd9, 0, 0, 32'h0);
    settle();
    checkOutput("lu_c1_stall", {26'd0, bus.stall_o}, 32'h07);
    checkOutput("lu_c1_lu", {31'd0, bus.lu_stall_o}, 32'h1);
    advance();
    settle();
    checkOutput("lu_c2_stall", {26'd0, bus.stall_o}, 32'h07);
    checkOutput("lu_c2_lu", {31'd0, bus.lu_stall_o}, 32'h1);
    advance();
    settle();
    checkOutput("lu_c3_stall", {26'd0, bus.stall_o}, 32'h00);
    checkOutput("lu_c3_lu", {31'd0, bus.lu_stall_o}, 32'h0);
    checkOutput("lu_c3_cnt", bus.stall_cnt_o, 32'd2);

    // $0 destination is never a hazard
    advance();
    applyStimulus(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 32'h0);
    settle();
    checkOutput("r0_c0_stall", {26'd0, bus.stall_o}, 32'h00);
    advance();
    applyStimulus(0, 0, 0, 0, 5'd4, 5'd0, 5'd0, 0, 0, 32'h0);
    settle();
    checkOutput("r0_c1_stall", {26'd0, bus.stall_o}, 32'h00);
    advance();
    settle();
    checkOutput("r0_c2_stall", {26'd0, bus.stall_o}, 32'h00);
    checkOutput("r0_cnt", bus.stall_cnt_o, 32'd2);

    // Priority and scoreboard holding
    advance();
    applyStimulus(0, 0, 0, 1, 5'd8, 5'd1, 5'd2, 0, 0, 32'h0);
    settle();
    checkOutput("pr_load_stall", {26'd0, bus.stall_o}, 32'h00);
    advance();
    applyStimulus(0, 1, 1, 0, 5'd3, 5'd8, 5'd0, 0, 0, 32'h0);
    settle();
    checkOutput("pr_mem_stall", {26'd0, bus.stall_o}, 32'h1F);
    checkOutput("pr_mem_lu", {31'd0, bus.lu_stall_o}, 32'h0);
    advance();
    applyStimulus(0, 1, 0, 0, 5'd3, 5'd8, 5'd0, 0, 0, 32'h0);
    settle();
    checkOutput("pr_ex_stall", {26'd0, bus.stall_o}, 32'h0F);
    checkOutput("pr_ex_lu", {31'd0, bus.lu_stall_o}, 32'h0);
    advance();
    applyStimulus(0, 0, 0, 0, 5'd3, 5'd8, 5'd0, 0, 0, 32'h0);
    settle();
    checkOutput("pr_exhold_stall", {26'd0, bus.stall_o}, 32'h07);
    checkOutput("pr_exhold_lu", {31'd0, bus.lu_stall_o}, 32'h1);
    advance();
    applyStimulus(0, 0, 1, 0, 5'd3, 5'd8, 5'd0, 0, 0, 32'h0);
    settle();
    checkOutput("pr_mem2_stall", {26'd0, bus.stall_o}, 32'h1F);
    advance();
    applyStimulus(0, 0, 0, 0, 5'd3, 5'd8, 5'd0, 0, 0, 32'h0);
    settle();
    checkOutput("pr_memhold_stall", {26'd0, bus.stall_o}, 32'h07);
    checkOutput("pr_memhold_cnt", bus.stall_cnt_o, 32'd3);
    advance();
    settle();
    checkOutput("pr_done_stall", {26'd0, bus.stall_o}, 32'h00);
    checkOutput("pr_done_cnt", bus.stall_cnt_o, 32'd4);

    // Exception: freeze, then flush with the new PC; second exception dropped
    advance();
    applyStimulus(0, 0, 0, 1, 5'd10, 5'd1, 5'd2, 0, 0, 32'h0);
    settle();
    checkOutput("ex_load_stall", {26'd0, bus.stall_o}, 32'h00);
    advance();
    applyStimulus(0, 0, 1, 0, 5'd3, 5'd0, 5'd10, 0, 1, 32'hBFC0_0380);
    settle();
    checkOutput("ex_frz_stall", {26'd0, bus.stall_o}, 32'h3F);
    checkOutput("ex_frz_lu", {31'd0, bus.lu_stall_o}, 32'h0);
    checkOutput("ex_frz_flush", {31'd0, bus.flush_o}, 32'h0);
    advance();
    applyStimulus(0, 1, 1, 0, 5'd3, 5'd0, 5'd10, 0, 1, 32'h1234_5678);
    settle();
    checkOutput("ex_fl_flush", {31'd0, bus.flush_o}, 32'h1);
    checkOutput("ex_fl_new_pc", bus.new_pc_o, 32'hBFC0_0380);
    checkOutput("ex_fl_stall", {26'd0, bus.stall_o}, 32'h00);
    checkOutput("ex_fl_lu", {31'd0, bus.lu_stall_o}, 32'h0);
    advance();
    applyStimulus(0, 0, 0, 0, 5'd3, 5'd0, 5'd10, 0, 0, 32'h0);
    settle();
    checkOutput("ex_after_flush", {31'd0, bus.flush_o}, 32'h0);
    checkOutput("ex_after_stall", {26'd0, bus.stall_o}, 32'h00);
    checkOutput("ex_after_new_pc", bus.new_pc_o, 32'hBFC0_0380);
    checkOutput("ex_after_cnt", bus.stall_cnt_o, 32'd4);

    // Branch squash: a squashed load is not recorded
    advance();
    applyStimulus(0, 0, 0, 1, 5'd9, 5'd1, 5'd2, 1, 0, 32'h0);
    settle();
    checkOutput("br_sq_stall", {26'd0, bus.stall_o}, 32'h00);
    advance();
    applyStimulus(0, 0, 0, 0, 5'd3, 5'd9, 5'd0, 0, 0, 32'h0);
    settle();
    checkOutput("br_reader_stall", {26'd0, bus.stall_o}, 32'h00);

    // Branch together with load-use: stall stays, squashed load not recorded
    advance();
    applyStimulus(0, 0, 0, 1, 5'd11, 5'd1, 5'd2, 0, 0, 32'h0);
    settle();
    advance();
    applyStimulus(0, 0, 0, 1, 5'd12, 5'd11, 5'd0, 1, 0, 32'h0);
    settle();
    checkOutput("brlu_stall", {26'd0, bus.stall_o}, 32'h07);
    checkOutput("brlu_lu", {31'd0, bus.lu_stall_o}, 32'h1);
    advance();
    applyStimulus(0, 0, 0, 0, 5'd3, 5'd12, 5'd0, 0, 0, 32'h0);
    settle();
    checkOutput("brlu_next_stall", {26'd0, bus.stall_o}, 32'h00);
    checkOutput("brlu_cnt", bus.stall_cnt_o, 32'd5);

    // Asynchronous reset in the middle of FLUSH
    advance();
    applyStimulus(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 32'h8000_0180);
    settle();
    checkOutput("ar_frz_stall", {26'd0, bus.stall_o}, 32'h3F);
    advance();
    applyStimulus(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 32'h0);
    checkOutput("ar_fl_flush", {31'd0, bus.flush_o}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("ar_flush", {31'd0, bus.flush_o}, 32'h0);
    checkOutput("ar_stall", {26'd0, bus.stall_o}, 32'h00);
    checkOutput("ar_cnt", bus.stall_cnt_o, 32'd0);
    checkOutput("ar_new_pc", bus.new_pc_o, 32'h0);
    #1;
    rst = 1'b0;
    advance();
    settle();
    checkOutput("ar_idle_flush", {31'd0, bus.flush_o}, 32'h0);
    checkOutput("ar_idle_stall", {26'd0, bus.stall_o}, 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
